// File: rtl/id_alloc_arbiter_if.sv
// Bundle of request/grant/free/status signals between requesters and the ID pool.
interface id_alloc_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int LOG_N_REQ = 2,
  parameter int LOG_DEPTH = 3
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     gnt;
  logic [LOG_N_REQ-1:0] gnt_idx;
  logic [LOG_DEPTH-1:0] alloc_id;
  logic                 free_valid;
  logic [LOG_DEPTH-1:0] free_id;
  logic [LOG_DEPTH:0]   count;
  logic                 empty;
  logic                 err_double_free;

  modport master (
    output req_valid, free_valid, free_id,
    input  gnt, gnt_idx, alloc_id, count, empty, err_double_free
  );

  modport slave (
    input  req_valid, free_valid, free_id,
    output gnt, gnt_idx, alloc_id, count, empty, err_double_free
  );
endinterface

// File: rtl/id_alloc_arbiter.sv
// Round-robin arbiter handing out IDs from a free-list FIFO; returned IDs are
// checked against an in-use bitmap so double frees are dropped and flagged.
module id_alloc_arbiter #(
  parameter int N_REQ     = 4,
  parameter int LOG_N_REQ = 2,
  parameter int LOG_DEPTH = 3
) (
  input logic               clk,
  input logic               rst,
  id_alloc_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  typedef logic [LOG_DEPTH:0] ptr_t;

  logic [LOG_DEPTH-1:0] r_fifo [DEPTH];
  ptr_t                 r_rd_ptr;
  ptr_t                 r_wr_ptr;
  ptr_t                 r_count;
  logic [DEPTH-1:0]     r_in_use;
  logic [LOG_N_REQ-1:0] r_last_grant;
  logic                 r_err;

  logic [LOG_N_REQ-1:0] w_sel;
  logic                 w_empty;
  logic                 w_grant;
  logic                 w_push;
  logic                 w_dbl_free;
  logic [LOG_DEPTH-1:0] w_head;
  logic [DEPTH-1:0]     w_set_mask;
  logic [DEPTH-1:0]     w_clr_mask;

  function automatic logic [LOG_N_REQ-1:0] f_rr_idx(input logic [LOG_N_REQ-1:0] last,
                                                    input int off);
    int sum;
    sum = (int'(last) + off) % N_REQ;
    return sum[LOG_N_REQ-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] f_req_onehot(input logic [LOG_N_REQ-1:0] idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  function automatic logic [DEPTH-1:0] f_id_onehot(input logic [LOG_DEPTH-1:0] id);
    logic [DEPTH-1:0] one;
    one = {{(DEPTH-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

  // Round-robin pick: scan offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    w_sel = {LOG_N_REQ{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      w_sel = bus.req_valid[f_rr_idx(r_last_grant, k)] ? f_rr_idx(r_last_grant, k) : w_sel;
    end
  end

  // Grant/pop/push qualification; a same-cycle free never feeds the grant because grant looks only at r_count.
  always_comb begin
    w_empty    = (r_count == {(LOG_DEPTH+1){1'b0}});
    w_grant    = ~rst & ~w_empty & (|bus.req_valid);
    w_head     = r_fifo[r_rd_ptr[LOG_DEPTH-1:0]];
    w_push     = bus.free_valid & r_in_use[bus.free_id];
    w_dbl_free = bus.free_valid & ~r_in_use[bus.free_id];
    w_set_mask = w_grant ? f_id_onehot(w_head) : {DEPTH{1'b0}};
    w_clr_mask = w_push ? f_id_onehot(bus.free_id) : {DEPTH{1'b0}};
  end

  // Output drive; alloc_id always shows the FIFO head so it is deterministic even without a grant.
  always_comb begin
    bus.gnt             = w_grant ? f_req_onehot(w_sel) : {N_REQ{1'b0}};
    bus.gnt_idx         = w_grant ? w_sel : {LOG_N_REQ{1'b0}};
    bus.alloc_id        = w_head;
    bus.count           = r_count;
    bus.empty           = w_empty;
    bus.err_double_free = r_err;
  end

  // Pool state: reset refills the FIFO with 0..DEPTH-1 and forgets every outstanding ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_fifo[k] <= LOG_DEPTH'(k);
      end
      r_rd_ptr     <= {(LOG_DEPTH+1){1'b0}};
      r_wr_ptr     <= ptr_t'(DEPTH);
      r_count      <= ptr_t'(DEPTH);
      r_in_use     <= {DEPTH{1'b0}};
      r_last_grant <= LOG_N_REQ'(N_REQ - 1);
      r_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rd_ptr     <= r_rd_ptr + ptr_t'(1);
        r_last_grant <= w_sel;
      end
      if (w_push) begin
        r_fifo[r_wr_ptr[LOG_DEPTH-1:0]] <= bus.free_id;
        r_wr_ptr                         <= r_wr_ptr + ptr_t'(1);
      end
      // A valid free targets an in-use ID, which can never be the head being granted.
      r_in_use <= (r_in_use | w_set_mask) & ~w_clr_mask;
      case ({w_push, w_grant})
        2'b10:   r_count <= r_count + ptr_t'(1);
        2'b01:   r_count <= r_count - ptr_t'(1);
        default: r_count <= r_count;
      endcase
      if (w_dbl_free) begin
        r_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_alloc_arbiter.sv
// Directed-vector bench: stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_id_alloc_arbiter;
  logic clk;
  logic rst;

  id_alloc_arbiter_if #(.N_REQ(4), .LOG_N_REQ(2), .LOG_DEPTH(3)) u_if ();

  id_alloc_arbiter #(.N_REQ(4), .LOG_N_REQ(2), .LOG_DEPTH(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       gnt_only;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic [2:0] id;
    logic [3:0] cnt;
    logic       emp;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    if (got != want) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %0d expected %0d", n_vec, nm, got, want);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      n_vec++;
      chk("gnt", int'(u_if.gnt), int'(e.gnt));
      if (!e.gnt_only) begin
        chk("gnt_idx", int'(u_if.gnt_idx), int'(e.idx));
        chk("alloc_id", int'(u_if.alloc_id), int'(e.id));
        chk("count", int'(u_if.count), int'(e.cnt));
        chk("empty", int'(u_if.empty), int'(e.emp));
        chk("err_double_free", int'(u_if.err_double_free), int'(e.err));
      end
    end
  end

  task automatic step(input logic rv, input logic [3:0] req, input logic fv,
                      input logic [2:0] fid, input logic og, input logic [3:0] eg,
                      input logic [2:0] eid, input logic [3:0] ec, input logic eerr);
    exp_t x;
    rst              = rv;
    u_if.req_valid   = req;
    u_if.free_valid  = fv;
    u_if.free_id     = fid;
    x.gnt_only = og;
    x.gnt      = eg;
    x.idx      = idx_of(eg);
    x.id       = eid;
    x.cnt      = ec;
    x.emp      = (ec == 4'd0);
    x.err      = eerr;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Reset cycle with every requester asking: grant must stay low.
  task automatic rstc();
    step(1'b1, 4'b1111, 1'b0, 3'd0, 1'b1, 4'b0000, 3'd0, 4'd0, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    u_if.req_valid  = 4'b0000;
    u_if.free_valid = 1'b0;
    u_if.free_id    = 3'd0;
    @(posedge clk);
    #1;
    rstc();
    rstc();

    // Four-way round robin from reset
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b0001, 3'd0, 4'd8, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b0010, 3'd1, 4'd7, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b0100, 3'd2, 4'd6, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b1000, 3'd3, 4'd5, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 4'b0000, 3'd4, 4'd4, 1'b0);
    rstc();

    // Drain the whole pool through one requester
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0, 4'b0100, 3'(k), 4'(8 - k), 1'b0);
    end
    step(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0, 4'b0000, 3'd0, 4'd0, 1'b0);

    // Empty pool: no same-cycle bypass, then pointer wrap, push+pop, double free
    step(1'b0, 4'b0010, 1'b1, 3'd5, 1'b0, 4'b0000, 3'd0, 4'd0, 1'b0);
    step(1'b0, 4'b0010, 1'b0, 3'd0, 1'b0, 4'b0010, 3'd5, 4'd1, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 4'b0000, 3'd1, 4'd0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 3'd2, 1'b0, 4'b0000, 3'd1, 4'd0, 1'b0);
    step(1'b0, 4'b0001, 1'b1, 3'd3, 1'b0, 4'b0001, 3'd2, 4'd1, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 3'd3, 1'b0, 4'b0000, 3'd3, 4'd1, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 4'b0000, 3'd3, 4'd1, 1'b1);
    rstc();

    // Free of a never-allocated ID right after reset
    step(1'b0, 4'b0000, 1'b1, 3'd3, 1'b0, 4'b0000, 3'd0, 4'd8, 1'b0);
    step(1'b0, 4'b0001, 1'b0, 3'd0, 1'b0, 4'b0001, 3'd0, 4'd8, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 4'b0000, 3'd1, 4'd7, 1'b1);
    rstc();

    // Two requesters alternate
    step(1'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 4'b0001, 3'd0, 4'd8, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 4'b1000, 3'd1, 4'd7, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 4'b0001, 3'd2, 4'd6, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 4'b1000, 3'd3, 4'd5, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 4'b0001, 3'd4, 4'd4, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 4'b1000, 3'd5, 4'd3, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 4'b0000, 3'd6, 4'd2, 1'b0);
    rstc();

    // Reset mid-operation abandons outstanding IDs
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b0001, 3'd0, 4'd8, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b0010, 3'd1, 4'd7, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b0100, 3'd2, 4'd6, 1'b0);
    rstc();
    step(1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 4'b0001, 3'd0, 4'd8, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 3'd1, 1'b0, 4'b0000, 3'd1, 4'd7, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 4'b0000, 3'd1, 4'd7, 1'b1);

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending vectors, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
